// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset release sequencer.
// The widths depend on the instance parameters, so they are computed by functions.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    WAIT_ACK = 2'd1,
    GAP      = 2'd2,
    DONE     = 2'd3
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

  // CNT_W = clog2(max(HOLD, GAP, TIMEOUT) + 1), never narrower than one bit
  function automatic int cnt_width(input int hold, input int gap, input int tmo);
    int w;
    w = $clog2(max3(hold, gap, tmo) + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // IDX_W = clog2(NUM_DOMAINS), kept at least one bit wide for a single domain
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_req_sync.sv
// Single-bit flop chain that brings the asynchronous reset request into the clock domain.
module reset_req_sync #(
  parameter int SYNC_DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] chain_r;

  // shift the request through SYNC_DEPTH flops, cleared by the block reset
  always_ff @(posedge clock) begin
    if (reset) begin
      chain_r <= {SYNC_DEPTH{1'b0}};
    end else begin
      chain_r <= {chain_r[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = chain_r[SYNC_DEPTH-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Stretches a reset request, then releases per-domain resets one at a time,
// waiting for each domain's ack (or a timeout) and an idle gap before the next.
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int SYNC_DEPTH  = 3,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_req_async,
  input  logic                   io_sw_req,
  output logic [NUM_DOMAINS-1:0] io_domain_reset,
  input  logic [NUM_DOMAINS-1:0] io_domain_ack,
  output logic                   io_busy,
  output logic                   io_done,
  output logic                   io_timeout_err
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
  localparam int IDX_W = idx_width(NUM_DOMAINS);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TMO_CNT   = CNT_W'(ACK_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic             TMO_EN    = (ACK_TIMEOUT > 0) ? 1'b1 : 1'b0;

  logic                   req_sync_s;
  logic                   req_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic [IDX_W-1:0]       idx_r;
  logic [IDX_W-1:0]       idx_nxt_s;
  logic                   ack_sel_s;
  logic                   tmo_hit_s;
  logic                   err_set_s;
  logic                   advance_s;
  logic [NUM_DOMAINS-1:0] domain_reset_r;
  logic [NUM_DOMAINS-1:0] domain_reset_nxt_s;
  logic                   busy_r;
  logic                   busy_nxt_s;
  logic                   done_r;
  logic                   done_nxt_s;
  logic                   err_r;
  logic                   err_nxt_s;

  reset_req_sync #(
    .SYNC_DEPTH (SYNC_DEPTH)
  ) u_req_sync (
    .clock (clock),
    .reset (reset),
    .d     (io_req_async),
    .q     (req_sync_s)
  );

  assign req_s = req_sync_s | io_sw_req;

  // pick the ack of the domain currently being released; other acks are ignored
  always_comb begin
    ack_sel_s = 1'b0;
    for (int j = 0; j < NUM_DOMAINS; j++) begin
      ack_sel_s = ack_sel_s | (io_domain_ack[j] & (idx_r == IDX_W'(j)));
    end
  end

  // the error flag goes up the cycle the timeout count completes; one cycle later
  // the missing ack is treated as received
  assign tmo_hit_s = TMO_EN & (state_r == WAIT_ACK) & (cnt_r == TMO_CNT);
  assign err_set_s = TMO_EN & (state_r == WAIT_ACK) & ~ack_sel_s & (cnt_r == TMO_LAST);
  assign advance_s = ack_sel_s | tmo_hit_s;

  // state, counter and domain index registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= HOLD;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // next-state logic; a request restarts the whole sequence from any state
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    if (req_s) begin
      state_nxt_s = HOLD;
      cnt_nxt_s   = {CNT_W{1'b0}};
      idx_nxt_s   = {IDX_W{1'b0}};
    end else begin
      case (state_r)
        HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            state_nxt_s = WAIT_ACK;
            cnt_nxt_s   = {CNT_W{1'b0}};
            idx_nxt_s   = {IDX_W{1'b0}};
          end else begin
            cnt_nxt_s   = cnt_r + CNT_W'(1);
          end
        end
        WAIT_ACK: begin
          if (advance_s) begin
            cnt_nxt_s = {CNT_W{1'b0}};
            if (idx_r == LAST_IDX) begin
              state_nxt_s = DONE;
            end else if (GAP_CYCLES == 0) begin
              state_nxt_s = WAIT_ACK;
              idx_nxt_s   = idx_r + IDX_W'(1);
            end else begin
              state_nxt_s = GAP;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_r == GAP_LAST) begin
            state_nxt_s = WAIT_ACK;
            cnt_nxt_s   = {CNT_W{1'b0}};
            idx_nxt_s   = idx_r + IDX_W'(1);
          end else begin
            cnt_nxt_s   = cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          state_nxt_s = DONE;
        end
        default: begin
          state_nxt_s = HOLD;
          cnt_nxt_s   = {CNT_W{1'b0}};
          idx_nxt_s   = {IDX_W{1'b0}};
        end
      endcase
    end
  end

  // output decode from the next state so every output comes straight off a flop
  always_comb begin
    domain_reset_nxt_s = {NUM_DOMAINS{1'b1}};
    case (state_nxt_s)
      HOLD: begin
        domain_reset_nxt_s = {NUM_DOMAINS{1'b1}};
      end
      WAIT_ACK, GAP: begin
        for (int j = 0; j < NUM_DOMAINS; j++) begin
          domain_reset_nxt_s[j] = (IDX_W'(j) > idx_nxt_s);
        end
      end
      DONE: begin
        domain_reset_nxt_s = {NUM_DOMAINS{1'b0}};
      end
      default: begin
        domain_reset_nxt_s = {NUM_DOMAINS{1'b1}};
      end
    endcase
    busy_nxt_s = (state_nxt_s != DONE);
    done_nxt_s = (state_nxt_s == DONE);
    if (req_s) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r | err_set_s;
    end
  end

  // registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      domain_reset_r <= {NUM_DOMAINS{1'b1}};
      busy_r         <= 1'b1;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      domain_reset_r <= domain_reset_nxt_s;
      busy_r         <= busy_nxt_s;
      done_r         <= done_nxt_s;
      err_r          <= err_nxt_s;
    end
  end

  assign io_domain_reset = domain_reset_r;
  assign io_busy         = busy_r;
  assign io_done         = done_r;
  assign io_timeout_err  = err_r;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Directed bench: one default instance and one with a short ack timeout share all inputs.
module tb_reset_release_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_async = 1'b0;
  logic       sw_req = 1'b0;
  logic [3:0] ack = 4'h0;

  logic [3:0] d_rst, t_rst;
  logic       d_busy, d_done, d_err;
  logic       t_busy, t_done, t_err;

  int cur = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  reset_release_sequencer dut (
    .clock(clock), .reset(reset), .io_req_async(req_async), .io_sw_req(sw_req),
    .io_domain_reset(d_rst), .io_domain_ack(ack),
    .io_busy(d_busy), .io_done(d_done), .io_timeout_err(d_err)
  );

  reset_release_sequencer #(.ACK_TIMEOUT(10)) dut_to (
    .clock(clock), .reset(reset), .io_req_async(req_async), .io_sw_req(sw_req),
    .io_domain_reset(t_rst), .io_domain_ack(ack),
    .io_busy(t_busy), .io_done(t_done), .io_timeout_err(t_err)
  );

  typedef struct {
    int         cyc;
    bit         start;
    logic       sw;
    logic [3:0] ack;
    logic [3:0] exp_rst;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clock);
    #1;
    cur++;
  endtask

  task automatic goto(input int n);
    if (n < cur) begin
      n_chk++;
      n_fail++;
      $display("FAIL goto: target cycle %0d already passed (now %0d)", n, cur);
    end else begin
      while (cur < n) step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sw_req = 1'b0;
    req_async = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    cur = 0;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %b, expected %b", name, cur, act, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [3:0] r, input logic b,
                       input logic dn, input logic e);
    chk({tag, ".domain_reset"}, d_rst, r);
    chk({tag, ".busy"}, {3'b000, d_busy}, {3'b000, b});
    chk({tag, ".done"}, {3'b000, d_done}, {3'b000, dn});
    chk({tag, ".timeout_err"}, {3'b000, d_err}, {3'b000, e});
  endtask

  task automatic chk_t(input string tag, input logic [3:0] r, input logic b,
                       input logic dn, input logic e);
    chk({tag, ".to.domain_reset"}, t_rst, r);
    chk({tag, ".to.busy"}, {3'b000, t_busy}, {3'b000, b});
    chk({tag, ".to.done"}, {3'b000, t_done}, {3'b000, dn});
    chk({tag, ".to.timeout_err"}, {3'b000, t_err}, {3'b000, e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cur);
    $fatal(1, "watchdog");
  end

  initial begin
    // immediate acks: release at 16, 25, 34, 43; DONE the cycle after the last ack
    vecs.push_back('{0,  1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{15, 1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{16, 1'b0, 1'b0, 4'hF, 4'hE, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{24, 1'b0, 1'b0, 4'hF, 4'hE, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{25, 1'b0, 1'b0, 4'hF, 4'hC, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{33, 1'b0, 1'b0, 4'hF, 4'hC, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{34, 1'b0, 1'b0, 4'hF, 4'h8, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{42, 1'b0, 1'b0, 4'hF, 4'h8, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{43, 1'b0, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{44, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0});
    // ack[1] arrives at 40 -> bit2 at 49; ack[0] toggling meanwhile is ignored
    vecs.push_back('{0,  1'b1, 1'b0, 4'hD, 4'hF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{24, 1'b0, 1'b0, 4'hD, 4'hE, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{25, 1'b0, 1'b0, 4'hD, 4'hC, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{30, 1'b0, 1'b0, 4'hC, 4'hC, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{35, 1'b0, 1'b0, 4'hD, 4'hC, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{39, 1'b0, 1'b0, 4'hD, 4'hC, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{40, 1'b0, 1'b0, 4'hF, 4'hC, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{48, 1'b0, 1'b0, 4'hF, 4'hC, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{49, 1'b0, 1'b0, 4'hF, 4'h8, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{58, 1'b0, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{59, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0});

    foreach (vecs[i]) begin
      if (vecs[i].start) begin
        ack = vecs[i].ack;
        do_reset();
      end else begin
        goto(vecs[i].cyc);
      end
      sw_req = vecs[i].sw;
      ack = vecs[i].ack;
      chk_d($sformatf("vec%0d", i), vecs[i].exp_rst, vecs[i].exp_busy,
            vecs[i].exp_done, vecs[i].exp_err);
    end

    // timeout instance: ack[2] never comes -> error at 44, bit3 at 53, DONE at 54
    ack = 4'hB;
    do_reset();
    goto(34); chk_t("tmo34", 4'h8, 1'b1, 1'b0, 1'b0);
    goto(43); chk_t("tmo43", 4'h8, 1'b1, 1'b0, 1'b0);
    goto(44); chk_t("tmo44", 4'h8, 1'b1, 1'b0, 1'b1);
    goto(52); chk_t("tmo52", 4'h8, 1'b1, 1'b0, 1'b1);
    goto(53); chk_t("tmo53", 4'h0, 1'b1, 1'b0, 1'b1);
    goto(54); chk_t("tmo54", 4'h0, 1'b0, 1'b1, 1'b1);
    goto(60); sw_req = 1'b1;
    goto(61); sw_req = 1'b0;
    chk_t("tmo_swclr", 4'hF, 1'b1, 1'b0, 1'b0);

    // software pulse during the gap after domain 1
    ack = 4'hF;
    do_reset();
    goto(28); chk_d("sw28", 4'hC, 1'b1, 1'b0, 1'b0);
    sw_req = 1'b1;
    goto(29); sw_req = 1'b0;
    chk_d("sw29", 4'hF, 1'b1, 1'b0, 1'b0);
    goto(44); chk_d("sw44", 4'hF, 1'b1, 1'b0, 1'b0);
    goto(45); chk_d("sw45", 4'hE, 1'b1, 1'b0, 1'b0);

    // async request held five cycles from DONE
    ack = 4'hF;
    do_reset();
    goto(50); chk_d("as50", 4'h0, 1'b0, 1'b1, 1'b0);
    req_async = 1'b1;
    goto(53); chk_d("as53", 4'h0, 1'b0, 1'b1, 1'b0);
    goto(54); chk_d("as54", 4'hF, 1'b1, 1'b0, 1'b0);
    goto(55); req_async = 1'b0;
    goto(73); chk_d("as73", 4'hF, 1'b1, 1'b0, 1'b0);
    goto(74); chk_d("as74", 4'hE, 1'b1, 1'b0, 1'b0);

    // synchronous reset while waiting on domain 2
    ack = 4'hB;
    do_reset();
    goto(34); chk_d("rs34", 4'h8, 1'b1, 1'b0, 1'b0);
    goto(45); chk_t("rs45", 4'h8, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    goto(46); reset = 1'b0;
    chk_d("rs46", 4'hF, 1'b1, 1'b0, 1'b0);
    chk_t("rs46", 4'hF, 1'b1, 1'b0, 1'b0);
    goto(61); chk_d("rs61", 4'hF, 1'b1, 1'b0, 1'b0);
    goto(62); chk_d("rs62", 4'hE, 1'b1, 1'b0, 1'b0);
    chk_t("rs62", 4'hE, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
